// File: rtl/spart_core.sv
// spart_core: one 8N1 serial port behind a 4-register, 8-bit tri-state bus.
// Register map: 00 TX/RX data, 01 status {6'b0, tbr, rda},
// 10 divisor low, 11 divisor high.
// A programmable divisor produces a baud enable at 16x the bit rate. Both
// the transmitter and the receiver count 16 enables per bit.
module spart_core #(
  parameter logic [15:0] DEF_DIV    = 16'h0515,
  parameter int          OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  // The tick counters are 4 bits wide, so only 16x oversampling fits.
  // TICK_LAST ends a full bit. TICK_HALF ends the half bit that moves the
  // receiver from the start edge to the middle of the start bit.
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       bus_rd;
  logic       bus_wr;
  logic [7:0] bus_rdata;

  assign bus_rd = iocs & iorw;
  assign bus_wr = iocs & ~iorw;

  logic [15:0] div_q;
  logic [7:0]  rx_buf_q;
  logic        rda_q;
  logic        tbr_q;

  // Read mux: data, status or divisor bytes, chosen by ioaddr.
  always_comb begin
    bus_rdata = 8'h00;
    case (ioaddr)
      2'b00:   bus_rdata = rx_buf_q;
      2'b01:   bus_rdata = {6'b0, tbr_q, rda_q};
      2'b10:   bus_rdata = div_q[7:0];
      default: bus_rdata = div_q[15:8];
    endcase
  end

  // The core drives the bus only during a selected read.
  assign databus = bus_rd ? bus_rdata : 8'bz;

  // ---------------------------------------------------------------------
  // Divisor register and baud-enable generator
  // ---------------------------------------------------------------------
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        baud_en;

  // Divisor bytes are loaded by bus writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DEF_DIV;
    end else if (bus_wr && ioaddr == 2'b10) begin
      div_q[7:0] <= databus;
    end else if (bus_wr && ioaddr == 2'b11) begin
      div_q[15:8] <= databus;
    end
  end

  // The down-counter fires an enable at zero and then reloads, so the
  // enable period is divisor+1 clocks. Writing the high byte reloads the
  // counter at once with the complete new divisor. A frame that is in
  // flight continues at the new rate.
  always_comb begin
    baud_en = (cnt_q == 16'd0);
    cnt_d   = cnt_q - 16'd1;
    if (bus_wr && ioaddr == 2'b11) begin
      cnt_d = {databus, div_q[7:0]};
    end else if (baud_en) begin
      cnt_d = div_q;
    end
  end

  // Baud counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= DEF_DIV;
    else     cnt_q <= cnt_d;
  end

  // ---------------------------------------------------------------------
  // Transmitter: one buffer byte plus a shifter
  // ---------------------------------------------------------------------
  state_t     tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q,  tx_tick_d;
  logic [2:0] tx_bit_q,   tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_buf_q,   tx_buf_d;
  logic       tbr_d;
  logic       txd_q,      txd_d;
  logic       tx_bit_end;

  // TX next state. The buffer is moved into the shifter as soon as it is
  // full, so the bus can queue the next byte while the current one shifts.
  // tbr_q selects exactly one writer of tbr: a bus write can only clear it
  // while tbr_q=1, and the FSM can only set it while tbr_q=0.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_buf_d   = tx_buf_q;
    tbr_d      = tbr_q;
    tx_bit_end = baud_en && (tx_tick_q == TICK_LAST);

    if (bus_wr && ioaddr == 2'b00 && tbr_q) begin
      tx_buf_d = databus;
      tbr_d    = 1'b0;
    end

    if (tx_state_q != S_IDLE && baud_en) begin
      tx_tick_d = tx_tick_q + 4'd1;
    end

    case (tx_state_q)
      S_IDLE: begin
        tx_tick_d = 4'd0;
        if (!tbr_q) begin
          tx_shift_d = tx_buf_q;
          tbr_d      = 1'b1;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b1, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
        end
      end
      default: begin
        // At the end of the stop bit, a byte that is already buffered starts
        // its frame without an idle bit in between.
        if (tx_bit_end) begin
          if (!tbr_q) begin
            tx_shift_d = tx_buf_q;
            tbr_d      = 1'b1;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
    endcase

    // txd is registered so that the pin does not glitch. It follows the
    // state that this edge enters.
    case (tx_state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = tx_shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // TX state registers. On reset the line is idle and the buffer is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_buf_q   <= 8'h00;
      tbr_q      <= 1'b1;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_buf_q   <= tx_buf_d;
      tbr_q      <= tbr_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver: synchronizer, shifter and one buffer byte
  // ---------------------------------------------------------------------
  logic       rx_meta_q;
  logic       rx_sync_q;
  state_t     rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q,  rx_tick_d;
  logic [2:0] rx_bit_q,   rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_buf_d;
  logic       rda_d;
  logic       rx_bit_end;

  // Two-flop synchronizer for the asynchronous rxd pin. It resets to idle
  // high so that reset does not produce a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX next state. The receiver confirms the start bit at its middle and
  // then samples each later bit 16 ticks apart, near the middle of the bit.
  // A data read clears rda, but a frame that completes on the same edge
  // sets rda again, so the new data wins.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rda_d      = rda_q;
    rx_bit_end = baud_en && (rx_tick_q == TICK_LAST);

    if (bus_rd && ioaddr == 2'b00) begin
      rda_d = 1'b0;
    end

    if (rx_state_q != S_IDLE && baud_en) begin
      rx_tick_d = rx_tick_q + 4'd1;
    end

    case (rx_state_q)
      S_IDLE: begin
        rx_tick_d = 4'd0;
        if (!rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (baud_en && rx_tick_q == TICK_HALF) begin
          // If the line is high again at the middle of the start bit, it
          // was only a glitch.
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end
      end
      default: begin
        // The frame is kept only if the stop bit is high. It overwrites any
        // byte that has not been read yet.
        if (rx_bit_end) begin
          if (rx_sync_q) begin
            rx_buf_d = rx_shift_q;
            rda_d    = 1'b1;
          end
          rx_state_d = S_IDLE;
        end
      end
    endcase
  end

  // RX state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
    end
  end

  assign rda = rda_q;
  assign tbr = tbr_q;
  assign txd = txd_q;

endmodule

// File: tb/tb_spart_core.sv
// Directed testbench for spart_core. Inputs change on the falling edge and
// outputs are sampled there too, half a clock away from the active edge.
module tb_spart_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       rxd;

  logic [7:0] tb_data;
  logic       tb_drive;
  logic [7:0] rd_val;

  int checks = 0;
  int errors = 0;

  logic cap [0:1399];

  assign databus = tb_drive ? tb_data : 8'bz;

  always #5 clk = ~clk;

  spart_core dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_data = d; tb_drive = 1'b1;
    @(negedge clk);
    iocs = 1'b0; tb_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  // Wait, with a bound, for txd to go low, then record n samples with one
  // sample per clock.
  task automatic capture(input int n);
    int w;
    w = 0;
    @(negedge clk);
    while (txd !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("tx_start_seen", 16'(w < 3000), 16'd1);
    for (int i = 0; i < n; i++) begin
      cap[i] = txd;
      @(negedge clk);
    end
  endtask

  // Check one frame in the capture. The start bit begins near index base
  // and each bit lasts 64 clocks, so every bit is sampled near its middle.
  task automatic check_frame(input string tag, input int base, input logic [7:0] b);
    chk($sformatf("%s_start", tag), 16'(cap[base + 30]), 16'd0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_bit%0d", tag, i), 16'(cap[base + 92 + 64 * i]), 16'(b[i]));
    chk($sformatf("%s_stop", tag), 16'(cap[base + 604]), 16'd1);
  endtask

  // Send one 8N1 frame on rxd at 64 clocks per bit. The low time of a bad
  // stop bit is set by stoplen.
  task automatic send_rx(input logic [7:0] b, input logic stopv, input int stoplen);
    @(negedge clk);
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (64) @(negedge clk);
    end
    rxd = stopv;
    repeat (stoplen) @(negedge clk);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    int r;
    int f;
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    tb_data = 8'h00; tb_drive = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and register reads.
    chk("rst_rda", 16'(rda), 16'd0);
    chk("rst_tbr", 16'(tbr), 16'd1);
    chk("rst_txd", 16'(txd), 16'd1);
    bus_read(2'b01, rd_val); chk("rst_status", 16'(rd_val), 16'h02);
    bus_read(2'b11, rd_val); chk("rst_div_hi", 16'(rd_val), 16'h05);
    bus_read(2'b10, rd_val); chk("rst_div_lo", 16'(rd_val), 16'h15);
    bus_read(2'b00, rd_val); chk("rst_rxbuf", 16'(rd_val), 16'h00);

    // Set the divisor to 3: 4 clocks per tick, 64 clocks per bit.
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, rd_val); chk("div_lo", 16'(rd_val), 16'h03);
    bus_read(2'b11, rd_val); chk("div_hi", 16'(rd_val), 16'h00);

    // Transmit A5. tbr is low for exactly one cycle.
    bus_write(2'b00, 8'hA5);
    chk("a5_tbr_low", 16'(tbr), 16'd0);
    @(negedge clk);
    chk("a5_tbr_back", 16'(tbr), 16'd1);
    capture(700);
    check_frame("a5", 0, 8'hA5);

    // Receive 3C. The status read leaves rda set and the data read clears it.
    send_rx(8'h3C, 1'b1, 64);
    chk("3c_rda", 16'(rda), 16'd1);
    bus_read(2'b01, rd_val); chk("3c_status", 16'(rd_val), 16'h03);
    chk("3c_rda_after_status", 16'(rda), 16'd1);
    bus_read(2'b00, rd_val); chk("3c_data", 16'(rd_val), 16'h3C);
    chk("3c_rda_cleared", 16'(rda), 16'd0);

    // Back-to-back transmit: 22 is queued while 11 shifts, and its start
    // bit follows the stop bit of 11 with no idle bit.
    bus_write(2'b00, 8'h11);
    @(negedge clk);
    chk("b2b_tbr_free", 16'(tbr), 16'd1);
    bus_write(2'b00, 8'h22);
    chk("b2b_second_buffered", 16'(tbr), 16'd0);
    capture(1400);
    check_frame("b2b_11", 0, 8'h11);
    r = 0;
    for (int i = 541; i < 800; i++)
      if (r == 0 && cap[i - 1] == 1'b0 && cap[i] == 1'b1) r = i;
    f = 0;
    for (int i = r + 1; i < 800; i++)
      if (f == 0 && cap[i - 1] == 1'b1 && cap[i] == 1'b0) f = i;
    chk("b2b_stop_len", 16'(f - r), 16'd64);
    check_frame("b2b_22", f, 8'h22);
    chk("b2b_tbr_idle", 16'(tbr), 16'd1);

    // Framing error: a stop bit held low is discarded.
    send_rx(8'h55, 1'b0, 40);
    chk("ferr_rda", 16'(rda), 16'd0);
    // A 20-clock low glitch is rejected as a false start.
    @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_rda", 16'(rda), 16'd0);

    // Overrun: the second frame overwrites the first and rda stays set.
    send_rx(8'h01, 1'b1, 64);
    chk("ovr_rda1", 16'(rda), 16'd1);
    send_rx(8'h02, 1'b1, 64);
    chk("ovr_rda2", 16'(rda), 16'd1);
    bus_read(2'b00, rd_val); chk("ovr_data", 16'(rd_val), 16'h02);
    chk("ovr_rda_cleared", 16'(rda), 16'd0);

    // Reset during a transmit: the line returns high, the buffer empties
    // and no frame follows.
    bus_write(2'b00, 8'h5A);
    repeat (100) @(negedge clk);
    chk("rst_mid_txd_low", 16'(txd), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_txd", 16'(txd), 16'd1);
    chk("rst_mid_tbr", 16'(tbr), 16'd1);
    repeat (200) @(negedge clk);
    chk("rst_mid_idle", 16'(txd), 16'd1);
    bus_read(2'b11, rd_val); chk("rst_mid_div_hi", 16'(rd_val), 16'h05);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart_core.md
Name: spart_core

Overview:
- Special-purpose asynchronous receiver/transmitter: one 8N1 serial port behind a 4-address, 8-bit tri-state processor bus.
- Downstream of the bus master (processor/driver FSM), which programs the baud divisor, writes TX bytes and reads RX bytes.
- Contains a programmable baud-enable generator (16x oversampling), a TX buffer and shifter, and an RX synchronizer, shifter and buffer.

Parameters:
- DEF_DIV, 16'h0515, divisor used from reset until the bus writes one.
- OVERSAMPLE, 16, baud-enable ticks per serial bit. Fixed; only 16 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- iocs  in  1  bus chip select
- iorw  in  1  1 = read (core drives databus), 0 = write
- ioaddr  in  2  00 TX/RX data, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  bidirectional data
- rda  out  1  receive data available
- tbr  out  1  transmit buffer ready (empty)
- txd  out  1  serial out, idle high
- rxd  in  1  serial in, asynchronous

Behaviour:
- Reset values: rda=0, tbr=1, txd=1, databus=Z, divisor=DEF_DIV, baud counter=DEF_DIV, both FSMs IDLE, RX buffer 8'h00.
- Bus drive (combinational):
  - databus is driven only while iocs=1 and iorw=1.
  - ioaddr 00 drives the RX buffer; 01 drives {6'b0, tbr, rda}; 10 and 11 drive the divisor low/high byte.
  - Otherwise databus is Z.
- Bus writes are sampled at the clk edge while iocs=1 and iorw=0:
  - 10: divisor[7:0] <= databus.
  - 11: divisor[15:8] <= databus, and the baud counter reloads with {databus, divisor[7:0]} at the same edge.
  - 00: if tbr=1, TX buffer <= databus and tbr=0 from the next cycle. If tbr=0 the write is dropped.
  - 01: ignored.
- RX read: an edge with iocs=1, iorw=1, ioaddr=00 clears rda at that edge. Data is valid on databus during that cycle. A status read does not clear rda.
- Baud generator:
  - 16-bit down-counter; a 1-cycle en pulse fires when the count is 0, and the counter reloads with divisor.
  - en period = divisor+1 clk cycles. Divisor 0 gives en every cycle.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: when tbr=0, the shifter loads the buffer and tbr returns to 1 on the next edge, so a second byte can be buffered during transmission.
  - Each state lasts 16 en ticks. START drives txd=0; DATA shifts 8 bits LSB first; STOP drives txd=1.
  - After STOP: go to IDLE, or straight to START if tbr=0 (back-to-back frames, no extra idle bit).
- RX FSM (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchronizer; the FSM uses the synchronized value.
  - IDLE → START on synchronized rxd=0.
  - START: after 8 en ticks, if rxd=1 it is a false start → IDLE; else → DATA.
  - DATA: sample every 16 en ticks; 8 bits, LSB first.
  - STOP: sample after 16 ticks. If stop=1, RX buffer <= shifter and rda=1; if stop=0 (framing error), discard the frame and leave rda unchanged. Then → IDLE.
- Boundary rules:
  - Overrun: a new frame completing while rda=1 overwrites the buffer; rda stays 1.
  - Completion coincides with an RX data read: the new data wins and rda=1 after the edge.
  - Divisor change mid-frame: in-flight frames continue at the new rate from the reload. No abort.
  - rst mid-frame: txd=1 immediately at the edge; both FSMs go to IDLE; buffered data is lost.
- Width: all counters wrap-free. Bit counter 3 bits, tick counter 4 bits.

Test Plan:
- Reset, then status read (iocs=1, iorw=1, ioaddr=01) → databus=8'h02; txd=1. Read of ioaddr 11 → 8'h05.
- Write 10←8'h03, 11←8'h00, then TX write 8'hA5 → tbr=0 for 1 cycle. txd: start bit 0 for 64 clks, then bits 1,0,1,0,0,1,0,1 (64 clks each), then stop 1.
- Divisor 3; drive rxd with frame 8'h3C at 64 clks/bit → rda=1 after the stop-bit sample. Data read returns 8'h3C; rda=0 after that edge.
- Two back-to-back TX writes 8'h11, 8'h22 → second accepted while first shifts; the stop bit of 8'h11 is followed immediately by the start bit of 8'h22.
- RX frame with stop=0 → rda stays 0. A 20-clk low glitch on rxd (divisor 3) → rejected as false start, rda stays 0.
- Two RX frames 8'h01 then 8'h02 with no read between → rda=1, read returns 8'h02. Assert rst mid-TX → txd=1, tbr=1 next cycle.
